// File: rtl/instruction_fetch_queue.sv
// Fetch stage: instruction memory, PC sequencer with IDLE/FETCH/HALTED control,
// and a prefetch queue that delivers {pc_plus4, instr} packets to decode.
module instruction_fetch_queue #(
    parameter int          DATA_WIDTH = 32,
    parameter int          IMEM_DEPTH = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    localparam int         AW         = $clog2(IMEM_DEPTH),
    localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic                    i_start,
    input  logic                    i_load_en,
    input  logic [AW-1:0]           i_load_addr,
    input  logic [DATA_WIDTH-1:0]   i_load_data,
    input  logic                    i_redirect,
    input  logic [DATA_WIDTH-1:0]   i_redirect_addr,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [2*DATA_WIDTH-1:0] o_if,
    output logic [DATA_WIDTH-1:0]   o_pc,
    output logic [CW-1:0]           o_count,
    output logic                    o_halted
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * DATA_WIDTH;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [DATA_WIDTH-1:0]   pc_reg;
    logic [PW-1:0]           rd_ptr_reg;
    logic [PW-1:0]           wr_ptr_reg;
    logic [CW-1:0]           count_reg;

    logic [DATA_WIDTH-1:0]   imem [IMEM_DEPTH];
    logic [EW-1:0]           fifo_mem [FIFO_DEPTH];

    logic [DATA_WIDTH-1:0]   instr;
    logic [DATA_WIDTH-1:0]   pc_plus4;
    logic [DATA_WIDTH-1:0]   redirect_pc;
    logic                    valid;
    logic                    pop;
    logic                    push;
    logic                    is_halt;

    // Combinational read: a load to the same word this cycle is seen next cycle.
    assign instr       = imem[pc_reg[AW+1:2]];
    assign pc_plus4    = pc_reg + DATA_WIDTH'(4);
    assign redirect_pc = i_redirect_addr & ~DATA_WIDTH'(3);
    assign is_halt     = (instr == DATA_WIDTH'(HALT_INSTR));

    assign valid = (count_reg != '0);
    assign pop   = valid && i_ready && !i_redirect;
    assign push  = (state_reg == FETCH) && i_enable && !i_redirect
                   && ((count_reg < FULL_COUNT) || pop);

    always_ff @(posedge clk) begin
        if (i_load_en) begin
            imem[i_load_addr] <= i_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {pc_plus4, instr};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (i_redirect) begin
            // Redirect wins over everything: flush, retarget, leave HALTED.
            pc_reg     <= redirect_pc;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            if (state_reg == HALTED) begin
                state_reg <= FETCH;
            end
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                pc_reg     <= pc_plus4;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (push && is_halt) begin
                        state_reg <= HALTED;
                    end
                end
                HALTED:  state_reg <= HALTED;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_valid  = valid;
    assign o_if     = valid ? fifo_mem[rd_ptr_reg] : '0;
    assign o_pc     = pc_reg;
    assign o_count  = count_reg;
    assign o_halted = (state_reg == HALTED);

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench: a scoreboard queue holds the packets decode should receive;
// a negedge monitor compares every accepted head entry against it.
module tb_instruction_fetch_queue;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_enable, i_start, i_load_en, i_redirect, i_ready;
    logic [AW-1:0] i_load_addr;
    logic [DW-1:0] i_load_data, i_redirect_addr;
    logic          o_valid, o_halted;
    logic [2*DW-1:0] o_if;
    logic [DW-1:0] o_pc;
    logic [CW-1:0] o_count;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    instruction_fetch_queue dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_start(i_start),
        .i_load_en(i_load_en), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
        .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr), .i_ready(i_ready),
        .o_valid(o_valid), .o_if(o_if), .o_pc(o_pc), .o_count(o_count), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    function automatic logic [31:0] w(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] v(input int i);
        return 32'h2000_0000 + 32'(i);
    endfunction

    function automatic logic [63:0] pk(input logic [31:0] pc4, input logic [31:0] ins);
        return {pc4, ins};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        i_load_en   = 1'b1;
        i_load_addr = AW'(addr);
        i_load_data = data;
        tick();
        i_load_en   = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while ((o_count != 0 || exp_q.size() != 0) && n < 40) begin
            tick();
            n++;
        end
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        check({name, "_count0"}, 64'(o_count), 64'd0);
    endtask

    task automatic redirect(input logic [31:0] addr);
        i_redirect      = 1'b1;
        i_redirect_addr = addr;
        tick();
        i_redirect      = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst && o_valid && i_ready && !i_redirect) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %h expected none", o_if);
            end else begin
                e = exp_q.pop_front();
                check("pop_packet", o_if, e);
                $display("pop t=%0t pc4=%h instr=%h", $time, o_if[63:32], o_if[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b0;
        i_enable = 1'b0; i_start = 1'b0; i_load_en = 1'b0; i_load_addr = '0;
        i_load_data = '0; i_redirect = 1'b0; i_redirect_addr = '0; i_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_if", o_if, 64'd0);
        check("rst_pc", 64'(o_pc), 64'd0);
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_halted", 64'(o_halted), 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) load(i, w(i));
        for (int i = 8; i < 12; i++) load(i, v(i));
        load(255, 32'hABCD_0255);

        // Sequential fetch, first packet two cycles after start
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(32'(4 * i + 4), w(i)));
        i_ready = 1'b1; i_enable = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_lat_valid0", 64'(o_valid), 64'd0);
        tick();
        check("start_lat_valid1", 64'(o_valid), 64'd1);
        check("start_first_if", o_if, pk(32'd4, w(0)));
        for (int i = 0; i < 7; i++) tick();
        i_enable = 1'b0;
        wait_empty("seq");
        check("seq_pc", 64'(o_pc), 64'd32);

        // Queue full: fill, freeze, then push+pop at full
        i_ready = 1'b0; i_enable = 1'b1;
        redirect(32'd0);
        check("full_redir_count", 64'(o_count), 64'd0);
        check("full_redir_pc", 64'(o_pc), 64'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(pk(32'(4 * i + 4), w(i)));
        exp_q.push_back(pk(32'd20, w(4)));
        for (int i = 0; i < 6; i++) tick();
        check("full_count", 64'(o_count), 64'd4);
        check("full_pc_frozen", 64'(o_pc), 64'd16);
        check("full_head", o_if, pk(32'd4, w(0)));
        i_ready = 1'b1;
        tick();
        i_enable = 1'b0;
        check("full_pushpop_count", 64'(o_count), 64'd4);
        check("full_pushpop_pc", 64'(o_pc), 64'd20);
        wait_empty("full");

        // Redirect flush with three entries queued and ready high
        i_ready = 1'b0; i_enable = 1'b1;
        tick(); tick(); tick();
        i_enable = 1'b0;
        check("flush_pre_count", 64'(o_count), 64'd3);
        exp_q.push_back(pk(32'h14, w(4)));
        i_ready = 1'b1; i_enable = 1'b1;
        redirect(32'h13);
        i_ready = 1'b0;
        check("flush_count", 64'(o_count), 64'd0);
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_pc", 64'(o_pc), 64'h10);
        tick();
        i_enable = 1'b0;
        check("flush_bubble_valid", 64'(o_valid), 64'd1);
        check("flush_target_if", o_if, pk(32'h14, w(4)));
        i_ready = 1'b1;
        wait_empty("flush");

        // HALT at word 3
        load(3, HALT);
        exp_q.push_back(pk(32'd4, w(0)));
        exp_q.push_back(pk(32'd8, w(1)));
        exp_q.push_back(pk(32'd12, w(2)));
        exp_q.push_back(pk(32'd16, HALT));
        i_enable = 1'b1; i_ready = 1'b1;
        redirect(32'd0);
        tick(); tick(); tick();
        check("halt_not_yet", 64'(o_halted), 64'd0);
        tick();
        check("halt_set", 64'(o_halted), 64'd1);
        check("halt_pc", 64'(o_pc), 64'd16);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick(); tick();
        check("halt_start_ignored", 64'(o_halted), 64'd1);
        check("halt_pc_hold", 64'(o_pc), 64'd16);
        wait_empty("halt");

        exp_q.push_back(pk(32'h24, v(8)));
        redirect(32'h20);
        check("resume_halted", 64'(o_halted), 64'd0);
        check("resume_pc", 64'(o_pc), 64'h20);
        tick();
        i_enable = 1'b0;
        wait_empty("resume");
        check("resume_pc_after", 64'(o_pc), 64'h24);

        // Enable toggled 1-in-2 with no pops
        i_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            i_enable = (k % 2 == 0);
            tick();
            check("en_toggle_count", 64'(o_count), 64'(k / 2 + 1));
        end
        i_enable = 1'b0;
        check("en_toggle_pc", 64'(o_pc), 64'h30);
        exp_q.push_back(pk(32'h28, v(9)));
        exp_q.push_back(pk(32'h2C, v(10)));
        exp_q.push_back(pk(32'h30, v(11)));
        i_ready = 1'b1;
        wait_empty("en_toggle");

        // Address wrap: 0x3FC reads word 255, 0x400 aliases to word 0
        exp_q.push_back(pk(32'h400, 32'hABCD_0255));
        exp_q.push_back(pk(32'h404, w(0)));
        i_enable = 1'b1;
        redirect(32'h3FC);
        tick();
        tick();
        i_enable = 1'b0;
        wait_empty("wrap");
        check("wrap_pc", 64'(o_pc), 64'h404);

        // Asynchronous reset with three entries queued
        i_ready = 1'b0; i_enable = 1'b1;
        redirect(32'd0);
        tick(); tick(); tick();
        i_enable = 1'b0;
        check("areset_pre_count", 64'(o_count), 64'd3);
        #2;
        rst = 1'b0;
        #1;
        check("areset_valid", 64'(o_valid), 64'd0);
        check("areset_count", 64'(o_count), 64'd0);
        check("areset_pc", 64'(o_pc), 64'd0);
        check("areset_if", o_if, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        exp_q.push_back(pk(32'd4, w(0)));
        exp_q.push_back(pk(32'd8, w(1)));
        exp_q.push_back(pk(32'd12, w(2)));
        exp_q.push_back(pk(32'd16, HALT));
        i_ready = 1'b1; i_enable = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_empty("restart");
        check("restart_halted", 64'(o_halted), 64'd1);
        check("restart_pc", 64'(o_pc), 64'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
